// File: rtl/sd_video_pkg.sv
// Shared types and constants for the SD-card video frame loader.
package sd_video_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RECV       = 3'd1,
    SECTOR_END = 3'd2,
    SKIP       = 3'd3,
    WAIT_BANK  = 3'd4
  } loader_state_e;

  localparam int SECTOR_BYTES     = 512;
  localparam int WORDS_PER_SECTOR = 256;

  // First card sector of a frame; 16-bit natural wrap.
  function automatic logic [15:0] frameBase(input logic [15:0] base,
                                            input int unsigned idx,
                                            input int unsigned spf);
    logic [31:0] off;
    off = idx * spf;
    return base + off[15:0];
  endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// Packs an even/odd byte pair into one 16-bit pixel write.
// Stage 1 latches the pair on the odd byte, stage 2 presents the write strobe,
// so the pixel appears one edge after its odd byte is sampled.
module byte_pair_packer #(
  parameter int SEC_W = 8
) (
  input  logic             DataClock,
  input  logic             Reset,
  input  logic             capture,
  input  logic [8:0]       byteIdx,
  input  logic [7:0]       InputData,
  input  logic             bank,
  input  logic [SEC_W-1:0] sector,
  output logic             PixelWe,
  output logic [15:0]      PixelData,
  output logic [SEC_W+8:0] PixelAddr
);

  logic [7:0]       hiByte;
  logic [1:0]       vldPipe;
  logic [15:0]      stgData;
  logic [SEC_W+8:0] stgAddr;
  logic             oddCapture;

  // Byte parity comes from the sector byte counter, which restarts every sector.
  assign oddCapture = capture && byteIdx[0];
  assign PixelWe    = vldPipe[1];

  // Even byte held, odd byte completes the pair, output stage one cycle later.
  always_ff @(posedge DataClock) begin
    if (Reset) begin
      hiByte    <= '0;
      vldPipe   <= '0;
      stgData   <= '0;
      stgAddr   <= '0;
      PixelData <= '0;
      PixelAddr <= '0;
    end else begin
      vldPipe <= {vldPipe[0], oddCapture};
      if (capture && !byteIdx[0]) hiByte <= InputData;
      if (oddCapture) begin
        stgData <= {hiByte, InputData};
        stgAddr <= {bank, sector, byteIdx[8:1]};
      end
      if (vldPipe[0]) begin
        PixelData <= stgData;
        PixelAddr <= stgAddr;
      end
    end
  end

endmodule

// File: rtl/sd_frame_loader.sv
// Captures SD sectors into a ping-pong frame buffer and sequences the card
// address; completed frames are handed to the video side via ready/ack.
module sd_frame_loader
  import sd_video_pkg::*;
#(
  parameter logic [15:0] BASE_SECTOR       = 16'd0,
  parameter int          SECTORS_PER_FRAME = 150,
  parameter int          NUM_FRAMES        = 1,
  localparam int         SEC_W             = $clog2(SECTORS_PER_FRAME)
) (
  input  logic             DataClock,
  input  logic             Reset,
  input  logic [7:0]       InputData,
  input  logic             EnableVideoRead,
  output logic [15:0]      InputAddress,
  output logic [15:0]      PixelData,
  output logic [SEC_W+8:0] PixelAddr,
  output logic             PixelWe,
  output logic             FrameReady,
  output logic             ReadBank,
  input  logic             FrameAck,
  output logic             FrameDone,
  output logic             ShortErr
);

  localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  loader_state_e    state;
  logic [9:0]       byteCnt;
  logic [SEC_W-1:0] sectorInFrame;
  logic [FI_W-1:0]  frameIdx;
  logic [FI_W-1:0]  frameIdxNext;
  logic             writeBank;
  logic             capture;
  logic             lastSector;
  logic             bankFree;

  // A byte is taken on the rising edge that starts a sector and on every
  // enabled edge while receiving.
  assign capture      = EnableVideoRead && (state == IDLE || state == RECV);
  assign lastSector   = (sectorInFrame == SEC_W'(SECTORS_PER_FRAME - 1));
  assign frameIdxNext = (frameIdx == FI_W'(NUM_FRAMES - 1)) ? '0 : frameIdx + FI_W'(1);
  // An ack arriving with the completion frees the read bank first.
  assign bankFree     = !FrameReady || FrameAck;

  byte_pair_packer #(.SEC_W(SEC_W)) uPacker (
    .DataClock (DataClock),
    .Reset     (Reset),
    .capture   (capture),
    .byteIdx   (byteCnt[8:0]),
    .InputData (InputData),
    .bank      (writeBank),
    .sector    (sectorInFrame),
    .PixelWe   (PixelWe),
    .PixelData (PixelData),
    .PixelAddr (PixelAddr)
  );

  // Sector/frame sequencing, bank ownership and error flag.
  always_ff @(posedge DataClock) begin
    if (Reset) begin
      state         <= IDLE;
      byteCnt       <= '0;
      sectorInFrame <= '0;
      frameIdx      <= '0;
      writeBank     <= 1'b0;
      ReadBank      <= 1'b1;
      FrameReady    <= 1'b0;
      FrameDone     <= 1'b0;
      ShortErr      <= 1'b0;
      InputAddress  <= BASE_SECTOR;
    end else begin
      FrameDone <= 1'b0;
      if (FrameAck) FrameReady <= 1'b0;
      case (state)
        IDLE: begin
          if (EnableVideoRead) begin
            state   <= RECV;
            byteCnt <= 10'd1;
          end
        end
        RECV: begin
          if (!EnableVideoRead) begin
            // Address is kept so the reader re-fetches the same sector.
            ShortErr <= 1'b1;
            byteCnt  <= '0;
            state    <= IDLE;
          end else if (byteCnt == 10'(SECTOR_BYTES - 1)) begin
            byteCnt <= '0;
            state   <= SECTOR_END;
          end else begin
            byteCnt <= byteCnt + 10'd1;
          end
        end
        SECTOR_END: begin
          if (!lastSector) begin
            sectorInFrame <= sectorInFrame + SEC_W'(1);
            InputAddress  <= InputAddress + 16'd1;
            state         <= SKIP;
          end else begin
            sectorInFrame <= '0;
            frameIdx      <= frameIdxNext;
            InputAddress  <= frameBase(BASE_SECTOR, 32'(frameIdxNext), SECTORS_PER_FRAME);
            if (bankFree) begin
              ReadBank   <= writeBank;
              writeBank  <= ~writeBank;
              FrameReady <= 1'b1;
              FrameDone  <= 1'b1;
              state      <= SKIP;
            end else begin
              state <= WAIT_BANK;
            end
          end
        end
        SKIP: begin
          if (!EnableVideoRead) state <= IDLE;
        end
        WAIT_BANK: begin
          // Sectors streamed here are dropped; the address is already the
          // next frame start so the reader simply repeats it.
          if (FrameAck) begin
            ReadBank   <= writeBank;
            writeBank  <= ~writeBank;
            FrameReady <= 1'b1;
            FrameDone  <= 1'b1;
            state      <= EnableVideoRead ? SKIP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_frame_loader.md
# sd_frame_loader

Downstream consumer of the SD SPI sector reader. Captures the 512-byte sector payload streamed on `InputData` while `EnableVideoRead` is high, and packs byte pairs into 16-bit pixels. Writes the pixels into one bank of an external ping-pong frame buffer and drives `InputAddress` with the next sector to fetch. Hands completed frames to the video side through a ready/ack handshake.

## Interface
Parameters:
- `BASE_SECTOR`, 16'd0: first sector of frame 0 on the card.
- `SECTORS_PER_FRAME`, 150: sectors per frame; `SEC_W = $clog2(SECTORS_PER_FRAME)`.
- `NUM_FRAMES`, 1: frames stored back to back; address wraps to `BASE_SECTOR` after the last.

Ports:
- `DataClock` in 1: byte clock shared with the SD reader.
- `Reset` in 1: synchronous, active-high; clock `DataClock`.
- `InputData` in 8: byte from reader, valid at each `DataClock` rising edge.
- `EnableVideoRead` in 1: high for ≥512 cycles per sector data phase.
- `InputAddress` out 16: sector address; the reader latches it on the `EnableVideoRead` rise.
- `PixelData` out 16: packed pixel, `{even byte, odd byte}`.
- `PixelAddr` out `1+SEC_W+8`: `{WriteBank, sector_in_frame, word_idx}`.
- `PixelWe` out 1: one-cycle write strobe.
- `FrameReady` out 1: a complete frame is available in `ReadBank`.
- `ReadBank` out 1: bank the video side must read.
- `FrameAck` in 1: one-cycle pulse; video side has released `ReadBank`.
- `FrameDone` out 1: one-cycle pulse on each frame completion.
- `ShortErr` out 1: sticky; a sector ended before 512 bytes.

## Operation
- **Reset values:**
  - `InputAddress = BASE_SECTOR`; `PixelData = 0`; `PixelAddr = 0`; `PixelWe = 0`.
  - `FrameReady = 0`; `ReadBank = 1`; `WriteBank = 0`; `FrameDone = 0`; `ShortErr = 0`.
  - State `IDLE`; `byte_cnt = 0`; `sector_in_frame = 0`; `frame_idx = 0`.
- **State machine:**
  - `IDLE`: on sampled `EnableVideoRead == 1`, go to `RECV`; that same edge captures byte 0.
  - `RECV`: each edge captures one byte, and `byte_cnt` increments (10 bits).
    - Even byte: held in the high register.
    - Odd byte: the next cycle drives `PixelWe = 1`, `PixelData = {hi, InputData}`, `word_idx = byte_cnt[8:1]`.
    - `EnableVideoRead` low before byte 511 is captured: set `ShortErr`, keep `InputAddress`, go to `IDLE`. The sector is re-fetched and overwrites the same addresses.
    - Byte 511 captured: go to `SECTOR_END`.
  - `SECTOR_END` (one cycle): increment `sector_in_frame`.
    - If `sector_in_frame` was not the last: `InputAddress += 1`; go to `SKIP`.
    - If it was the last: `sector_in_frame = 0`; advance `frame_idx`, wrapping at `NUM_FRAMES`; set `InputAddress = BASE_SECTOR + frame_idx*SECTORS_PER_FRAME`.
      - `FrameReady == 0` (or `FrameAck` this cycle): swap banks (`ReadBank <= WriteBank`, `WriteBank <= ~WriteBank`); set `FrameReady`; pulse `FrameDone`; go to `SKIP`.
      - Otherwise: go to `WAIT_BANK`.
  - `SKIP`: ignore bytes until `EnableVideoRead == 0`, then go to `IDLE`. This absorbs the reader's extra cycles after 512 bytes.
  - `WAIT_BANK`: `PixelWe` is held 0 and sectors streamed by the reader are discarded; `InputAddress` stays constant.
    - On `FrameAck`: swap banks, set `FrameReady`, pulse `FrameDone`.
    - Then go to `SKIP` if `EnableVideoRead == 1`, else `IDLE`.
- **`FrameAck` handling:** clears `FrameReady` in any state. When it coincides with a frame completion, the ack is applied first, so the result is one swap with `FrameReady = 1`.
- **Arithmetic:** address arithmetic is 16-bit unsigned with natural wrap; `BASE_SECTOR + NUM_FRAMES*SECTORS_PER_FRAME ≤ 2^16` is a parameter restriction.
- **Reset mid-sector:** takes priority over all other logic. Partial data is abandoned, writing restarts at bank 0 / sector 0, and the reader re-latches `BASE_SECTOR` on its next `EnableVideoRead` rise.

## Timing
- Pixel latency: the odd byte is sampled at edge N; `PixelWe`, `PixelData` and `PixelAddr` are valid after edge N+1 for one cycle.
- Sector throughput: 256 `PixelWe` pulses per sector, never two in consecutive cycles.
- Address update: `InputAddress` changes at edge N+1 after byte 511. It is stable well before the reader's next `EnableVideoRead` rise, which follows ≥7 command bytes.
- `FrameDone` is a single-cycle pulse, coincident with the `FrameReady` rise.
- `FrameAck` is sampled every cycle; it is ignored when `FrameReady == 0` and not completing.

## Structure
- **Package `sd_video_pkg`:**
  - State enum `IDLE`, `RECV`, `SECTOR_END`, `SKIP`, `WAIT_BANK`.
  - `SECTOR_BYTES = 512`, `WORDS_PER_SECTOR = 256`.
- **Sub-module `byte_pair_packer`:** even/odd byte register plus `PixelWe`/`PixelData` generation, enabled by `RECV`; reset clears its phase.
- The frame buffer RAM is external.

## Test plan
- Reset, then one sector of bytes 0x00..0xFF repeated, `EnableVideoRead` high 514 cycles → 256 `PixelWe`; word 0 = 0x0001, word 255 = 0xFEFF; `PixelAddr` 0..255; `InputAddress` = `BASE_SECTOR + 1`.
- `SECTORS_PER_FRAME = 2`, `NUM_FRAMES = 2`, 4 sectors with prompt acks → `FrameDone` twice, banks alternate, `InputAddress` sequence 1, 2, 3, 0 (wrap).
- Two frames without `FrameAck` → `WAIT_BANK`; a third sector is discarded (no `PixelWe`) and `InputAddress` is held. `FrameAck` → swap, `FrameDone`, writing resumes.
- `EnableVideoRead` drops after 300 bytes → `ShortErr = 1`, `InputAddress` unchanged; a full resend rewrites words 0..255 of the same sector.
- `FrameAck` in the same cycle as the last sector completes → single swap, `FrameReady` stays 1, no `WAIT_BANK`.
- `Reset` asserted at byte 100 of sector 3 → all outputs at reset values next cycle; the next sector is written at `PixelAddr` 0.
